// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, the 4x4 key map
// (indexed [row][column]), the debounce FSM state type and the accumulator
// limit.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'd1,     4'd2, 4'd3,     KEY_A},
        '{4'd4,     4'd5, 4'd6,     KEY_B},
        '{4'd7,     4'd8, 4'd9,     KEY_C},
        '{KEY_STAR, 4'd0, KEY_HASH, KEY_D}
    };

    localparam int unsigned VALUE_MAX = 8191;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 active-low keypad matrix.
// Drives one column low for SCAN_DIV cycles at a time, synchronizes the row
// lines and reduces each 4-column sweep to a single key (lowest column, then
// lowest row) or "none".
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   row         - row sense lines, active-low, asynchronous
//   col         - column drive lines, active-low, one-hot-low
//   sweep_done  - high on the last cycle of column 3 (sweep result valid)
//   sweep_hit   - a key was seen during the sweep
//   sweep_key   - code of the highest-priority key seen
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       sweep_done,
    output logic       sweep_hit,
    output logic [3:0] sweep_key
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       sync1_q, sync2_q;
    logic             hit_q, hit_d;
    logic [3:0]       key_q, key_d;
    logic             dwell_end;
    logic             col_hit;
    logic [1:0]       col_row;
    logic             cur_hit;
    logic [3:0]       cur_key;

    assign col = ~(4'b0001 << idx_q);

    always_comb begin
        dwell_end = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d     = dwell_end ? '0 : div_q + DIV_W'(1);
        idx_d     = dwell_end ? idx_q + 2'd1 : idx_q;

        // Scan downward so the lowest pressed row is the one left standing.
        col_hit = ~&sync2_q;
        col_row = 2'd0;
        for (int unsigned r = 4; r > 0; r--) begin
            if (!sync2_q[r-1]) col_row = 2'(r - 1);
        end

        // Earlier columns win, so a key already held in the sweep is kept.
        cur_hit = hit_q | col_hit;
        cur_key = hit_q ? key_q : KEY_MAP[col_row][idx_q];

        hit_d = hit_q;
        key_d = key_q;
        if (dwell_end) begin
            if (idx_q == 2'd3) begin
                hit_d = 1'b0;
                key_d = '0;
            end else begin
                hit_d = cur_hit;
                key_d = cur_key;
            end
        end

        sweep_done = dwell_end && (idx_q == 2'd3);
        sweep_hit  = cur_hit;
        sweep_key  = cur_key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            idx_q   <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            hit_q   <= 1'b0;
            key_q   <= '0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            sync1_q <= row;
            sync2_q <= sync1_q;
            hit_q   <= hit_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad decimal entry: scans a 4x4 keypad, debounces whole sweeps and
// accumulates digits into a 13-bit value.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   row          - keypad rows, active-low, asynchronous
//   col          - keypad columns, active-low drive
//   key_valid    - one-cycle pulse per accepted press
//   key_code     - code of last accepted key
//   value        - accumulated decimal value (0..8191)
//   value_valid  - one-cycle pulse when '#' commits the value
//   overflow     - sticky: a digit was rejected; cleared by 'A' or rst
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [12:0] value,
    output logic        value_valid,
    output logic        overflow
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic        sweep_done, sweep_hit;
    logic [3:0]  sweep_key;

    state_e             state_q, state_d;
    logic [3:0]         cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               key_valid_q;
    logic [3:0]         key_code_q, key_code_d;
    logic [12:0]        value_q, value_d;
    logic               ovf_q, ovf_d;
    logic               vvalid_q, vvalid_d;
    logic [16:0]        prod;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .sweep_done (sweep_done),
        .sweep_hit  (sweep_hit),
        .sweep_key  (sweep_key)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sweep_done) begin
            case (state_q)
                IDLE: begin
                    if (sweep_hit) begin
                        cand_d = sweep_key;
                        cnt_d  = CNT_ONE;
                        if (CNT_DONE == CNT_ONE) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sweep_hit && (sweep_key == cand_q)) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_DONE) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!sweep_hit) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_DONE == CNT_ONE) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (sweep_hit) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_DONE) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        key_code_d = accept ? cand_d : key_code_q;
    end

    // Accumulator acts on the registered key pulse, one cycle after it.
    always_comb begin
        value_d  = value_q;
        ovf_d    = ovf_q;
        vvalid_d = 1'b0;
        prod     = 17'(value_q) * 17'd10 + 17'(key_code_q);
        if (key_valid_q) begin
            if (is_digit(key_code_q)) begin
                if (prod <= 17'(VALUE_MAX)) value_d = prod[12:0];
                else                        ovf_d   = 1'b1;
            end else begin
                case (key_code_q)
                    KEY_A: begin
                        value_d = '0;
                        ovf_d   = 1'b0;
                    end
                    KEY_B:    value_d  = value_q / 13'd10;
                    KEY_HASH: vvalid_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            value_q     <= '0;
            ovf_q       <= 1'b0;
            vvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= accept;
            key_code_q  <= key_code_d;
            value_q     <= value_d;
            ovf_q       <= ovf_d;
            vvalid_q    <= vvalid_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign value       = value_q;
    assign value_valid = vvalid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: keypad matrix model, sweep-level reference
// model, scoreboard queues and a decoupled output monitor.
module tb_keypad_entry;

    localparam int unsigned SD  = 4;
    localparam int unsigned DS  = 2;
    localparam int          SWP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [12:0] value;
    logic        value_valid;
    logic        overflow;

    logic [15:0] held = '0;

    int total = 0;
    int bad   = 0;
    int kv_count = 0;
    int vv_count = 0;
    logic vv_prev = 1'b0;

    int exp_key[$];
    int exp_commit[$];

    // Key code at matrix position row*4+col.
    int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    bit m_down;
    int m_cand;
    int m_run;
    int m_rel;
    int m_val;
    bit m_ovf;
    bit pending;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .value       (value),
        .value_valid (value_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expected key codes and commit values as they appear.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            kv_count++;
            if (exp_key.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected key_valid: key_code=%0d none expected", key_code);
            end else begin
                check("key_code", int'(key_code), exp_key.pop_front());
            end
        end
        if (value_valid === 1'b1) begin
            vv_count++;
            if (vv_prev) begin
                total++;
                bad++;
                $display("FAIL value_valid width: high 2+ cycles, required 1");
            end else if (exp_commit.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected value_valid: value=%0d none expected", value);
            end else begin
                check("commit value", int'(value), exp_commit.pop_front());
            end
        end
        vv_prev = (value_valid === 1'b1);
    end

    function automatic int sweep_key(input logic [15:0] k);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (k[r*4+c]) return km[r*4+c];
        return -1;
    endfunction

    task automatic apply_key(input int k);
        if (k <= 9) begin
            if (m_val * 10 + k <= 8191) m_val = m_val * 10 + k;
            else                        m_ovf = 1'b1;
        end else if (k == 10) begin
            m_val = 0;
            m_ovf = 1'b0;
        end else if (k == 11) begin
            m_val = m_val / 10;
        end else if (k == 15) begin
            exp_commit.push_back(m_val);
        end
    endtask

    task automatic accept_key();
        m_down  = 1'b1;
        m_run   = 0;
        m_rel   = 0;
        pending = 1'b1;
        exp_key.push_back(m_cand);
        apply_key(m_cand);
    endtask

    // A press is a run of DS identical key sweeps started from rest; any
    // break in the run discards it. A held key is released by DS empty sweeps.
    task automatic model_sweep(input logic [15:0] k);
        int s = sweep_key(k);
        if (m_down) begin
            if (s < 0) begin
                m_rel++;
                if (m_rel == int'(DS)) begin
                    m_down = 1'b0;
                    m_rel  = 0;
                end
            end else begin
                m_rel = 0;
            end
        end else if (m_run > 0) begin
            if (s == m_cand) begin
                m_run++;
                if (m_run == int'(DS)) accept_key();
            end else begin
                m_run = 0;
            end
        end else if (s >= 0) begin
            m_cand = s;
            m_run  = 1;
            if (DS == 1) accept_key();
        end
    endtask

    // Called at the negedge of the first cycle of a sweep.
    task automatic run_sweeps(input logic [15:0] keys, input int n);
        held = keys;
        for (int s = 0; s < n; s++) begin
            for (int cyc = 0; cyc < SWP; cyc++) begin
                if (cyc == 0) begin
                    check("key_valid timing", int'(key_valid), int'(pending));
                    pending = 1'b0;
                end
                if (cyc % 4 == 0)
                    check("col drive", int'(col), 15 ^ (1 << (cyc / 4)));
                if (cyc == 8) begin
                    check("value", int'(value), m_val);
                    check("overflow", int'(overflow), int'(m_ovf));
                end
                @(negedge clk);
            end
            model_sweep(keys);
        end
    endtask

    task automatic reset_values();
        check("reset col", int'(col), 14);
        check("reset value", int'(value), 0);
        check("reset key_valid", int'(key_valid), 0);
        check("reset key_code", int'(key_code), 0);
        check("reset value_valid", int'(value_valid), 0);
        check("reset overflow", int'(overflow), 0);
    endtask

    task automatic model_reset();
        m_down  = 1'b0;
        m_cand  = 0;
        m_run   = 0;
        m_rel   = 0;
        m_val   = 0;
        m_ovf   = 1'b0;
        pending = 1'b0;
    endtask

    // Leaves the bench aligned to cycle 0 of a fresh sweep.
    task automatic do_reset();
        check("key_valid timing", int'(key_valid), int'(pending));
        pending = 1'b0;
        @(negedge clk);
        check("key queue drained", exp_key.size(), 0);
        check("commit queue drained", exp_commit.size(), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        reset_values();
    endtask

    task automatic press(input int code);
        int idx = 0;
        logic [15:0] k = '0;
        for (int i = 0; i < 16; i++) if (km[i] == code) idx = i;
        k[idx] = 1'b1;
        run_sweeps(k, 3);
        run_sweeps('0, 3);
    endtask

    initial begin
        int kv0;
        int vv0;
        logic [15:0] k;
        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        reset_values();

        // Single press of '5' held for 12 sweeps, then released.
        kv0 = kv_count;
        run_sweeps(16'h0001 << 5, 12);
        run_sweeps('0, 4);
        check("press 5 pulses", kv_count - kv0, 1);
        check("press 5 value", int'(value), 5);

        // Bounce on '7': present, absent, present, released.
        kv0 = kv_count;
        run_sweeps(16'h0001 << 8, 1);
        run_sweeps('0, 1);
        run_sweeps(16'h0001 << 8, 1);
        run_sweeps('0, 3);
        check("bounce pulses", kv_count - kv0, 0);

        // Overflow on the fourth digit, then clear.
        do_reset();
        press(8); press(1); press(9); press(2);
        check("overflow value", int'(value), 819);
        check("overflow flag", int'(overflow), 1);
        press(10);
        check("clear value", int'(value), 0);
        check("clear overflow", int'(overflow), 0);

        // Backspace and commit.
        do_reset();
        vv0 = vv_count;
        press(1); press(2); press(3); press(11); press(15);
        check("commit final value", int'(value), 12);
        check("commit pulses", vv_count - vv0, 1);

        // '1' and '2' together, reset mid-hold, keep holding.
        do_reset();
        run_sweeps(16'h0003, 4);
        check("priority key_code", int'(key_code), 1);
        do_reset();
        kv0 = kv_count;
        run_sweeps(16'h0003, 4);
        run_sweeps('0, 3);
        check("post-reset pulses", kv_count - kv0, 1);
        check("post-reset key_code", int'(key_code), 1);

        // Randomized presses, bounces, chords and resets.
        for (int it = 0; it < 80; it++) begin
            int sel = int'($urandom_range(0, 9));
            k = '0;
            if (sel < 7) begin
                k[$urandom_range(0, 15)] = 1'b1;
            end else if (sel < 9) begin
                k[$urandom_range(0, 15)] = 1'b1;
                k[$urandom_range(0, 15)] = 1'b1;
            end
            run_sweeps(k, int'($urandom_range(1, 4)));
            run_sweeps('0, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        run_sweeps('0, 3);
        check("final key queue drained", exp_key.size(), 0);
        check("final commit queue drained", exp_commit.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
